dmem_initiator: RTL

- Bus-initiator front end that turns single load/store requests from the core into accesses on the word-addressed memory port, then returns a one-cycle response.
- Sits between the mips datapath and the `memory` responder. Drives `wr_en`, address and write data, and waits for the responder's `ack`.
- One access in flight at a time. Misaligned and out-of-range addresses are rejected without touching memory.

---
 rtl/dmem_initiator.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dmem_initiator.sv
// Single-outstanding load/store initiator for the word-addressed data memory port.
// Optional ack timeout is enabled by defining DMEM_TIMEOUT_EN.
module dmem_initiator #(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wr_data,
    input  logic [31:0]       mem_rd_data,
    input  logic              mem_ack
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmem_initiator: TIMEOUT_CYCLES must be in 1..65535");
    end

    logic [1:0]        state, state_nx;
    logic              req_ready_nx;
    logic              resp_valid_nx;
    logic [DATA_W-1:0] resp_rdata_nx;
    logic              resp_err_nx;
    logic              mem_wr_en_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic [DATA_W-1:0] mem_wr_data_nx;
    logic              addr_fault;

`ifdef DMEM_TIMEOUT_EN
    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
`endif

    // Misaligned or beyond the memory's word range
    assign addr_fault = (req_addr[1:0] != 2'b00) ||
                        ((req_addr >> (ADDR_W + 2)) != 32'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            state       <= state_nx;
            req_ready   <= req_ready_nx;
            resp_valid  <= resp_valid_nx;
            resp_rdata  <= resp_rdata_nx;
            resp_err    <= resp_err_nx;
            mem_wr_en   <= mem_wr_en_nx;
            mem_addr    <= mem_addr_nx;
            mem_wr_data <= mem_wr_data_nx;
`ifdef DMEM_TIMEOUT_EN
            wait_cnt    <= wait_cnt_nx;
`endif
        end
    end

    // Next state and next registered outputs
    always_comb begin
        state_nx       = state;
        resp_rdata_nx  = resp_rdata;
        resp_err_nx    = resp_err;
        mem_wr_en_nx   = mem_wr_en;
        mem_addr_nx    = mem_addr;
        mem_wr_data_nx = mem_wr_data;
`ifdef DMEM_TIMEOUT_EN
        wait_cnt_nx    = wait_cnt;
`endif

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (addr_fault) begin
                        state_nx      = RESP;
                        resp_err_nx   = 1'b1;
                        resp_rdata_nx = '0;
                    end else begin
                        state_nx       = ACCESS;
                        mem_addr_nx    = req_addr[ADDR_W+1:2];
                        mem_wr_data_nx = req_wdata;
                        mem_wr_en_nx   = req_we;
`ifdef DMEM_TIMEOUT_EN
                        wait_cnt_nx    = '0;
`endif
                    end
                end
            end
            ACCESS: begin
                if (mem_ack) begin
                    state_nx      = RESP;
                    resp_err_nx   = 1'b0;
                    resp_rdata_nx = mem_wr_en ? '0 : mem_rd_data;
                    mem_wr_en_nx  = 1'b0;
                end
`ifdef DMEM_TIMEOUT_EN
                else if (wait_cnt == CNT_LAST) begin
                    state_nx      = RESP;
                    resp_err_nx   = 1'b1;
                    resp_rdata_nx = '0;
                    mem_wr_en_nx  = 1'b0;
                end else begin
                    wait_cnt_nx = wait_cnt + CNT_W'(1);
                end
`endif
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx     = IDLE;
                mem_wr_en_nx = 1'b0;
            end
        endcase

        req_ready_nx  = (state_nx == IDLE);
        resp_valid_nx = (state_nx == RESP);
    end

endmodule
